// File: rtl/premuat_pipe.sv
// Runtime-sized (4/8/16/32-point) butterfly reorder over an N-lane bus,
// registered through a valid/ready stage with a one-entry skid buffer.
module premuat_pipe #(
  parameter int N     = 32,
  parameter int W     = 28,
  parameter int TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic               i_enable,
  input  logic               i_inverse,
  input  logic [1:0]         i_size,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic [N*W-1:0]     i_data,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [TAG_W-1:0]   o_tag,
  output logic [N*W-1:0]     o_data
);

  localparam int unsigned NL = N;

  logic [N*W-1:0]   perm;
  logic             m_valid, s_valid, ready_q;
  logic [N*W-1:0]   m_data, s_data;
  logic [TAG_W-1:0] m_tag, s_tag;
  logic             accept, drain;

  // Each output lane selects its source lane; lanes at or above M pass through.
  always_comb begin
    int unsigned m;
    int unsigned h;
    int unsigned src;
    perm = i_data;
    m    = 32'd4 << i_size;
    if (m > NL) m = NL;
    h    = m / 2;
    for (int unsigned k = 0; k < NL; k++) begin
      src = k;
      if (i_enable && (k < m)) begin
        if (i_inverse) src = (k < h) ? (2 * k) : (2 * (k - h) + 1);
        else           src = (k[0] == 1'b0) ? (k / 2) : (h + k / 2);
      end
      perm[k*W +: W] = i_data[src*W +: W];
    end
  end

  assign accept  = i_valid & ready_q;
  assign drain   = m_valid & o_ready;
  assign i_ready = ready_q;
  assign o_valid = m_valid;
  assign o_data  = m_data;
  assign o_tag   = m_tag;

  // ready_q always mirrors !s_valid; it is updated alongside s_valid so it stays a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      ready_q <= 1'b1;
      m_data  <= '0;
      s_data  <= '0;
      m_tag   <= '0;
      s_tag   <= '0;
    end else begin
      if (s_valid && drain) begin
        m_data  <= s_data;
        m_tag   <= s_tag;
        s_valid <= 1'b0;
        ready_q <= 1'b1;
      end else if (accept && (!m_valid || drain)) begin
        m_data  <= perm;
        m_tag   <= i_tag;
        m_valid <= 1'b1;
      end else if (accept && m_valid && !o_ready) begin
        s_data  <= perm;
        s_tag   <= i_tag;
        s_valid <= 1'b1;
        ready_q <= 1'b0;
      end else if (drain) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
